// File: rtl/acq_poll_pkg.sv
// Shared state encoding and parameter limits for the acquisition status poller.
package acq_poll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    DELAY
  } poll_state_t;

  localparam int MAX_READ_LATENCY  = 4;
  localparam int MIN_POLL_INTERVAL = 1;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/acq_poll_timer.sv
// Loadable down-counter shared by the read-latency wait and the poll-interval delay.
module acq_poll_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/acq_status_poller.sv
// Avalon-MM read master that polls a status word until a match or a read limit is hit.
// Define ACQ_POLL_MASK_EN to add match_mask/match_value inputs for a masked compare.
module acq_status_poller
  import acq_poll_pkg::*;
#(
  parameter int ADDR_W        = 2,
  parameter int DATA_W        = 32,
  parameter int READ_LATENCY  = 1,
  parameter int POLL_INTERVAL = 16,
  parameter int TIMEOUT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    poll_addr,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
`ifdef ACQ_POLL_MASK_EN
  input  logic [DATA_W-1:0]    match_mask,
  input  logic [DATA_W-1:0]    match_value,
`endif
  output logic [ADDR_W-1:0]    avm_address,
  output logic                 avm_read,
  input  logic                 avm_waitrequest,
  input  logic [DATA_W-1:0]    avm_readdata,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic [DATA_W-1:0]    last_status,
  output logic [TIMEOUT_W-1:0] poll_count
);

  localparam int LAT      = clamp_int(READ_LATENCY, 1, MAX_READ_LATENCY);
  localparam int INTERVAL = (POLL_INTERVAL < MIN_POLL_INTERVAL) ? MIN_POLL_INTERVAL : POLL_INTERVAL;
  localparam int CNT_MAX  = (INTERVAL > LAT) ? INTERVAL : LAT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD      = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] INTERVAL_LOAD = CNT_W'(INTERVAL - 1);

  poll_state_t          state, state_next;
  logic [ADDR_W-1:0]    addr_q;
  logic [TIMEOUT_W-1:0] limit_q;
  logic [TIMEOUT_W-1:0] count_inc;
  logic                 accept, sample, hit, expire, matched;
  logic                 timer_load, timer_zero;
  logic [CNT_W-1:0]     timer_value;

  acq_poll_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .value (timer_value),
    .zero  (timer_zero)
  );

`ifdef ACQ_POLL_MASK_EN
  logic [DATA_W-1:0] mask_q, value_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q  <= '0;
      value_q <= '0;
    end else if (accept) begin
      mask_q  <= match_mask;
      value_q <= match_value;
    end
  end

  always_comb begin
    matched = ((avm_readdata & mask_q) == (value_q & mask_q));
  end
`else
  always_comb begin
    matched = avm_readdata[0];
  end
`endif

  // A start landing on a done/timed_out cycle is dropped so runs never overlap.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    sample      = 1'b0;
    hit         = 1'b0;
    expire      = 1'b0;
    timer_load  = 1'b0;
    timer_value = '0;
    count_inc   = (poll_count == '1) ? poll_count : poll_count + 1'b1;
    case (state)
      IDLE: begin
        if (start && !done && !timed_out) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          timer_load  = 1'b1;
          timer_value = LAT_LOAD;
          state_next  = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (timer_zero) begin
          sample = 1'b1;
          if (matched) begin
            hit        = 1'b1;
            state_next = IDLE;
          end else if ((limit_q != '0) && (count_inc == limit_q)) begin
            expire     = 1'b1;
            state_next = IDLE;
          end else begin
            timer_load  = 1'b1;
            timer_value = INTERVAL_LOAD;
            state_next  = DELAY;
          end
        end
      end
      DELAY: begin
        if (timer_zero) begin
          state_next = ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // busy stays up through the result pulse and drops on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      limit_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      last_status <= '0;
      poll_count  <= '0;
    end else begin
      state     <= state_next;
      done      <= hit;
      timed_out <= expire;
      if (accept) begin
        addr_q     <= poll_addr;
        limit_q    <= timeout_limit;
        poll_count <= '0;
        busy       <= 1'b1;
      end else if (done || timed_out) begin
        busy <= 1'b0;
      end
      if (sample) begin
        last_status <= avm_readdata;
        poll_count  <= count_inc;
      end
    end
  end

  assign avm_read    = (state == ISSUE);
  assign avm_address = addr_q;

endmodule

// File: tb/tb_acq_status_poller.sv
// Randomized bench for acq_status_poller: behavioural Avalon slave plus outcome model.
module tb_acq_status_poller;

  localparam int ADDR_W        = 2;
  localparam int DATA_W        = 32;
  localparam int READ_LATENCY  = 2;
  localparam int POLL_INTERVAL = 16;
  localparam int TIMEOUT_W     = 16;
  localparam int MIN_SPACING   = 1 + READ_LATENCY + POLL_INTERVAL;
  localparam int RUN_BUDGET    = 2000;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [ADDR_W-1:0]    poll_addr = '0;
  logic [TIMEOUT_W-1:0] timeout_limit = '0;
  logic [ADDR_W-1:0]    avm_address;
  logic                 avm_read;
  logic                 avm_waitrequest = 1'b0;
  logic [DATA_W-1:0]    avm_readdata = '0;
  logic                 busy, done, timed_out;
  logic [DATA_W-1:0]    last_status;
  logic [TIMEOUT_W-1:0] poll_count;
`ifdef ACQ_POLL_MASK_EN
  logic [DATA_W-1:0]    match_mask = 32'h1;
  logic [DATA_W-1:0]    match_value = 32'h1;
`endif

  int compared = 0;
  int mismatched = 0;

  logic [DATA_W-1:0] resp_q[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic              prev_stalled = 1'b0;
  int cycle = 0;
  int lat_cnt = 0;
  int last_accept = -1;
  int accepts = 0;
  int done_pulses = 0;
  int to_pulses = 0;
  int stall_force = 0;

  acq_status_poller #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .READ_LATENCY  (READ_LATENCY),
    .POLL_INTERVAL (POLL_INTERVAL),
    .TIMEOUT_W     (TIMEOUT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .poll_addr       (poll_addr),
    .timeout_limit   (timeout_limit),
`ifdef ACQ_POLL_MASK_EN
    .match_mask      (match_mask),
    .match_value     (match_value),
`endif
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .timed_out       (timed_out),
    .last_status     (last_status),
    .poll_count      (poll_count)
  );

  always #5 clk = ~clk;

  function automatic void check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  function automatic bit is_match(input logic [DATA_W-1:0] w);
`ifdef ACQ_POLL_MASK_EN
    return (w & match_mask) == (match_value & match_mask);
`else
    return w[0];
`endif
  endfunction

  // Off-sample-cycle data always satisfies the match rule, so a mistimed sample ends the run early.
  function automatic logic [DATA_W-1:0] garbage_word();
`ifdef ACQ_POLL_MASK_EN
    return (match_value & match_mask) | ($urandom & ~match_mask);
`else
    return $urandom | 32'h1;
`endif
  endfunction

  // Outcome of a run from the response list: first match ends it, else the read limit does.
  function automatic void model(input logic [DATA_W-1:0] r[$], input int limit,
                                output int n, output bit d, output bit t,
                                output logic [DATA_W-1:0] last);
    n = 0; d = 0; t = 0; last = '0;
    foreach (r[i]) begin
      n++;
      last = r[i];
      if (is_match(r[i])) begin d = 1; return; end
      if (limit != 0 && n == limit) begin t = 1; return; end
    end
  endfunction

  // Behavioural slave: drives waitrequest/readdata mid-cycle and watches the bus.
  always @(negedge clk) begin
    cycle++;
    if (prev_stalled) begin
      check_output("read_held", 64'(avm_read), 64'd1);
      check_output("addr_held", 64'(avm_address), 64'(prev_addr));
    end
    avm_readdata = garbage_word();
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0 && resp_q.size() > 0) avm_readdata = resp_q.pop_front();
    end
    if (done) done_pulses++;
    if (timed_out) to_pulses++;
    if (avm_read && stall_force > 0) begin
      avm_waitrequest = 1'b1;
      stall_force--;
    end else if (avm_read) begin
      avm_waitrequest = ($urandom_range(0, 3) == 0);
    end else begin
      avm_waitrequest = 1'($urandom_range(0, 1));
    end
    if (avm_read && !avm_waitrequest && !reset) begin
      check_output("one_outstanding", 64'(lat_cnt), 64'd0);
      check_output("read_addr", 64'(avm_address), 64'(exp_addr));
      if (last_accept >= 0)
        check_output("read_spacing_ok", 64'(cycle - last_accept >= MIN_SPACING), 64'd1);
      last_accept = cycle;
      lat_cnt = READ_LATENCY;
      accepts++;
    end
    prev_stalled = avm_read && avm_waitrequest && !reset;
    prev_addr = avm_address;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset_values(input string tag);
    check_output({tag, "_read"}, 64'(avm_read), 64'd0);
    check_output({tag, "_addr"}, 64'(avm_address), 64'd0);
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_done"}, 64'(done), 64'd0);
    check_output({tag, "_timed_out"}, 64'(timed_out), 64'd0);
    check_output({tag, "_last_status"}, 64'(last_status), 64'd0);
    check_output({tag, "_poll_count"}, 64'(poll_count), 64'd0);
  endtask

  task automatic begin_run(input logic [ADDR_W-1:0] addr, input int limit,
                           input logic [DATA_W-1:0] resp[$], input int stall);
    resp_q = resp;
    exp_addr = addr;
    last_accept = -1;
    accepts = 0;
    done_pulses = 0;
    to_pulses = 0;
    stall_force = stall;
    poll_addr = addr;
    timeout_limit = TIMEOUT_W'(limit);
    start = 1'b1;
    tick();
    start = 1'b0;
    poll_addr = ADDR_W'($urandom);
    timeout_limit = TIMEOUT_W'($urandom);
  endtask

  task automatic apply_stimulus(input string tag, input logic [ADDR_W-1:0] addr, input int limit,
                                input logic [DATA_W-1:0] resp[$], input int stall);
    int exp_n, waited;
    bit exp_d, exp_t;
    logic [DATA_W-1:0] exp_last;
    model(resp, limit, exp_n, exp_d, exp_t, exp_last);
    begin_run(addr, limit, resp, stall);
    check_output({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    waited = 0;
    while (!(done || timed_out) && waited < RUN_BUDGET) begin
      tick();
      waited++;
    end
    check_output({tag, "_finished_in_budget"}, 64'(waited < RUN_BUDGET), 64'd1);
    check_output({tag, "_done"}, 64'(done), 64'(exp_d));
    check_output({tag, "_timed_out"}, 64'(timed_out), 64'(exp_t));
    check_output({tag, "_busy_in_pulse"}, 64'(busy), 64'd1);
    check_output({tag, "_poll_count"}, 64'(poll_count), 64'(exp_n));
    check_output({tag, "_last_status"}, 64'(last_status), 64'(exp_last));
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output({tag, "_pulse_single"}, 64'(done | timed_out), 64'd0);
    check_output({tag, "_busy_cleared"}, 64'(busy), 64'd0);
    tick();
    check_output({tag, "_start_in_pulse_ignored"}, 64'(busy | avm_read), 64'd0);
    tick();
    check_output({tag, "_reads"}, 64'(accepts), 64'(exp_n));
    check_output({tag, "_done_pulses"}, 64'(done_pulses), 64'(exp_d));
    check_output({tag, "_to_pulses"}, 64'(to_pulses), 64'(exp_t));
    check_output({tag, "_stall_consumed"}, 64'(stall_force), 64'd0);
  endtask

  function automatic logic [DATA_W-1:0] nomatch_word();
    return $urandom & ~32'h1;
  endfunction

  function automatic logic [DATA_W-1:0] yes_word();
    return $urandom | 32'h1;
  endfunction

  initial begin
    logic [DATA_W-1:0] r[$];
    int waited;
    $display("[TB] start");
    repeat (3) tick();
    check_idle_reset_values("reset");
    reset = 1'b0;
    repeat (2) tick();

    r = '{32'h0, 32'h0, 32'h0, 32'h1};
    apply_stimulus("four_reads", 2'd3, 0, r, 0);

    r = '{yes_word()};
    apply_stimulus("stall5", 2'd1, 0, r, 5);

    r = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    apply_stimulus("timeout3", 2'd2, 3, r, 0);

    r = '{nomatch_word(), yes_word()};
    apply_stimulus("match_at_limit", 2'd0, 2, r, 0);

    r = '{nomatch_word()};
    apply_stimulus("limit1", 2'd1, 1, r, 0);

    // Reset lands in WAIT_DATA; the matching word arrives one cycle later and must be dropped.
    r = '{32'h1};
    begin_run(2'd2, 0, r, 0);
    waited = 0;
    while (accepts == 0 && waited < 100) begin
      tick();
      waited++;
    end
    check_output("rst_read_accepted", 64'(accepts), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_reset_values("rst_mid");
    repeat (READ_LATENCY + 4) tick();
    check_output("rst_no_done", 64'(done_pulses + to_pulses), 64'd0);
    check_output("rst_late_data_dropped", 64'(last_status), 64'd0);
    r = '{nomatch_word(), yes_word()};
    apply_stimulus("after_reset", 2'd3, 0, r, 0);

`ifdef ACQ_POLL_MASK_EN
    match_mask = 32'h6;
    match_value = 32'h4;
    r = '{32'h2, 32'h7, 32'h5};
    apply_stimulus("mask", 2'd1, 0, r, 0);
    match_mask = 32'h1;
    match_value = 32'h1;
`endif

    for (int it = 0; it < 6; it++) begin
      int len, lim;
      len = $urandom_range(1, 5);
      lim = $urandom_range(0, 4);
      r.delete();
      for (int j = 0; j < len - 1; j++) r.push_back(($urandom_range(0, 3) == 0) ? yes_word() : nomatch_word());
      r.push_back((lim == 0 || $urandom_range(0, 1) == 1) ? yes_word() : nomatch_word());
      if (lim != 0) for (int j = len; j < lim; j++) r.push_back(nomatch_word());
      apply_stimulus($sformatf("rand%0d", it), ADDR_W'($urandom), lim, r, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/acq_status_poller.md
Name: acq_status_poller

Overview:
- Avalon-MM read master (initiator) that polls a single-word status slave, such as the acquisition-done PIO, until a completion condition is met.
- Frees the Nios from busy-wait loops: firmware or a sequencer pulses start, and the block reports done or timed_out.
- Sits between the acquisition control logic and the system interconnect, addressing the status PIO's data register.

Parameters:
- ADDR_W, 2, width of avm_address (word address into the status slave).
- DATA_W, 32, width of avm_readdata.
- READ_LATENCY, 1, fixed slave read latency in cycles after command acceptance; legal range 1..4.
- POLL_INTERVAL, 16, idle cycles between consecutive reads; legal range 1 or more.
- TIMEOUT_W, 16, width of the poll counter and of timeout_limit.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle request to begin polling.
- poll_addr, in, ADDR_W, address to read; sampled on the accepted start.
- timeout_limit, in, TIMEOUT_W, maximum number of reads; 0 means unlimited; sampled on the accepted start.
- avm_address, out, ADDR_W, read address.
- avm_read, out, 1, read command.
- avm_waitrequest, in, 1, slave stall.
- avm_readdata, in, DATA_W, read data, valid READ_LATENCY cycles after acceptance.
- busy, out, 1, high from the accepted start until the done or timed_out cycle, inclusive.
- done, out, 1, one-cycle pulse when the condition is met.
- timed_out, out, 1, one-cycle pulse when the limit is reached without a match.
- last_status, out, DATA_W, most recently sampled readdata.
- poll_count, out, TIMEOUT_W, number of completed reads in the current or last run.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (port reset), sampled on the rising clk edge only.
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, timed_out=0, last_status=0, poll_count=0. FSM goes to IDLE.
- States: IDLE, ISSUE, WAIT_DATA, DELAY.
- IDLE:
  - start=1 captures poll_addr and timeout_limit, clears poll_count, sets busy, and moves to ISSUE on the next cycle.
  - start while not in IDLE is ignored; no queuing.
- ISSUE:
  - avm_read=1, avm_address=captured address.
  - Held stable while avm_waitrequest=1.
  - The cycle with avm_read=1 and waitrequest=0 is the acceptance cycle. Next state is WAIT_DATA; avm_read deasserts the following cycle.
- WAIT_DATA:
  - A latency counter samples avm_readdata exactly READ_LATENCY cycles after the acceptance edge. With latency 1, data is taken on the first WAIT_DATA cycle.
  - On the sample cycle: last_status <= readdata, and poll_count increments, saturating at its maximum.
  - If the match condition holds: done pulses on the cycle after the sample, busy clears with it, and the FSM returns to IDLE.
  - Else, if timeout_limit != 0 and the incremented count == timeout_limit: timed_out pulses the same way and the FSM returns to IDLE.
  - Otherwise: go to DELAY.
- Match and timeout on the same sample: done wins and timed_out stays 0.
- DELAY: counts POLL_INTERVAL cycles with avm_read=0, then goes to ISSUE.
- Match condition: avm_readdata[0]==1.
- At most one outstanding read at any time.
- Reset during ISSUE, WAIT_DATA or DELAY: avm_read is 0 from the next cycle, no done or timed_out pulse is produced, and any late readdata is ignored.
- start asserted in the same cycle as done or timed_out is ignored; a new start is accepted from IDLE on the following cycle.
- timeout_limit=1: exactly one read, then done or timed_out.

Optional Feature:
- Macro: ACQ_POLL_MASK_EN.
- With it defined:
  - Adds inputs match_mask[DATA_W] and match_value[DATA_W], both sampled on start.
  - Condition becomes (readdata & match_mask) == (match_value & match_mask).
  - match_mask=0 matches on the first read.
- Without it: no extra ports, and the condition is readdata[0]==1.

Decomposition:
- Shared package acq_poll_pkg:
  - state enum (IDLE, ISSUE, WAIT_DATA, DELAY);
  - constants MAX_READ_LATENCY=4 and MIN_POLL_INTERVAL=1.
- Optional sub-module acq_poll_timer: loadable down-counter used for both the latency wait and the interval delay, with load/value inputs and a zero flag.
- All other logic stays in the top-level module.

Test Plan:
- Slave readdata=0 for 3 reads, then 1; timeout_limit=0: exactly 4 reads, done pulses once, poll_count=4, last_status=1, reads spaced 16+ cycles apart.
- waitrequest held high for 5 cycles: avm_read and avm_address stay stable for all 5 cycles, a single read is accepted, and no duplicate read is issued.
- readdata always 0, timeout_limit=3: 3 reads, timed_out pulses once, done stays 0, busy falls with the pulse.
- Match on the read where count reaches timeout_limit=2: done=1 and timed_out=0.
- Reset asserted in WAIT_DATA with readdata=1 arriving the next cycle: no done pulse, all outputs at reset values; a new start after reset runs normally.
- ACQ_POLL_MASK_EN, mask=0x6, value=0x4; reads return 0x2, 0x7, 0x5: done after the 3rd read, last_status=0x5.
